// File: rtl/psum_accum.sv
// Multi-lane signed partial-sum accumulator with a one-entry valid/ready result register.
// Define PSUM_SAT_EN for saturating lane additions with sticky out_sat flags; otherwise sums wrap.
module psum_accum #(
    parameter int LANES = 2,
    parameter int IN_W  = 16,
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    logic [0:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] cnt_next;
    logic             is_last;
    logic             accept;

    logic [ACC_W-1:0] acc       [LANES];
    logic [ACC_W-1:0] lane_base [LANES];
    logic [ACC_W-1:0] lane_beat [LANES];
    logic [ACC_W-1:0] sum_next  [LANES];

`ifdef PSUM_SAT_EN
    logic [ACC_W:0]   sum_wide  [LANES];
    logic [LANES-1:0] lane_ovf;
    logic [LANES-1:0] sat_next;
    logic [LANES-1:0] sat_q;
    logic [LANES-1:0] out_sat_q;
`endif

    // The first beat of a group takes its length from cfg_len; later beats use the latched copy.
    always_comb begin
        eff_len  = (state == ST_IDLE) ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_q;
        cnt_next = (state == ST_IDLE) ? LEN_W'(1) : beat_cnt + LEN_W'(1);
        is_last  = (cnt_next == eff_len);
        in_ready = !clr && !(is_last && out_valid && !out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
`ifdef PSUM_SAT_EN
        lane_ovf = '0;
        sat_next = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            lane_base[i] = (state == ST_IDLE) ? '0 : acc[i];
            lane_beat[i] = {{(ACC_W-IN_W){in_data[i*IN_W+IN_W-1]}}, in_data[i*IN_W +: IN_W]};
`ifdef PSUM_SAT_EN
            sum_wide[i] = {lane_base[i][ACC_W-1], lane_base[i]} + {lane_beat[i][ACC_W-1], lane_beat[i]};
            lane_ovf[i] = sum_wide[i][ACC_W] ^ sum_wide[i][ACC_W-1];
            if (lane_ovf[i]) begin
                sum_next[i] = sum_wide[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                sum_next[i] = sum_wide[i][ACC_W-1:0];
            end
            sat_next[i] = ((state == ST_ACC) && sat_q[i]) || lane_ovf[i];
`else
            sum_next[i] = lane_base[i] + lane_beat[i];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
`ifdef PSUM_SAT_EN
            sat_q    <= '0;
`endif
        end else if (clr || (accept && is_last)) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
`ifdef PSUM_SAT_EN
            sat_q    <= '0;
`endif
        end else if (accept) begin
            state    <= ST_ACC;
            len_q    <= eff_len;
            beat_cnt <= cnt_next;
            for (int i = 0; i < LANES; i++) acc[i] <= sum_next[i];
`ifdef PSUM_SAT_EN
            sat_q    <= sat_next;
`endif
        end
    end

    // Loading a new result wins over consumption, so a same-cycle hand-off leaves out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef PSUM_SAT_EN
            out_sat_q <= '0;
`endif
        end else if (accept && is_last) begin
            out_valid <= 1'b1;
            for (int i = 0; i < LANES; i++) out_data[i*ACC_W +: ACC_W] <= sum_next[i];
`ifdef PSUM_SAT_EN
            out_sat_q <= sat_next;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PSUM_SAT_EN
    assign out_sat = out_sat_q;
`else
    assign out_sat = '0;
`endif

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: a 32-bit-accumulator instance for the main behaviour
// and a 17-bit-accumulator instance for the overflow case (expectations follow PSUM_SAT_EN).
module tb_psum_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_len;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_sat;

    logic [7:0]  ovf_cfg_len = 8'd8;
    logic        ovf_clr = 1'b0;
    logic        ovf_out_ready = 1'b1;
    logic        ovf_in_valid;
    logic        ovf_in_ready;
    logic [31:0] ovf_in_data;
    logic        ovf_out_valid;
    logic [33:0] ovf_out_data;
    logic [1:0]  ovf_out_sat;

    int errors = 0;
    int checks = 0;

`ifdef PSUM_SAT_EN
    localparam logic [16:0] OVF_SUM = 17'd65535;
    localparam logic [1:0]  OVF_SAT = 2'b01;
`else
    localparam logic [16:0] OVF_SUM = 17'h1FFF8;
    localparam logic [1:0]  OVF_SAT = 2'b00;
`endif

    always #5 clk = ~clk;

    psum_accum #(.LANES(2), .IN_W(16), .ACC_W(32), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    psum_accum #(.LANES(2), .IN_W(16), .ACC_W(17), .LEN_W(8)) dut_ovf (
        .clk(clk), .rst(rst), .cfg_len(ovf_cfg_len), .clr(ovf_clr),
        .in_valid(ovf_in_valid), .in_ready(ovf_in_ready), .in_data(ovf_in_data),
        .out_valid(ovf_out_valid), .out_ready(ovf_out_ready), .out_data(ovf_out_data), .out_sat(ovf_out_sat)
    );

    function automatic logic [31:0] pack_beat(input int lane0, input int lane1);
        return {lane1[15:0], lane0[15:0]};
    endfunction

    function automatic logic [63:0] pack_sum(input int lane0, input int lane1);
        return {lane1, lane0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input int lane0, input int lane1);
        in_valid = valid;
        in_data  = pack_beat(lane0, lane1);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_len = 8'd0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        ovf_in_valid = 1'b0; ovf_in_data = '0;
        tick();
        tick();
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_in_ready",  64'(in_ready),  64'd1);
        check_output("reset_out_data",  out_data,       64'd0);
        check_output("reset_out_sat",   64'(out_sat),   64'd0);
        rst = 1'b0;
        tick();

        // Basic four-beat group
        cfg_len = 8'd4;
        for (int k = 1; k <= 3; k++) begin
            apply_stimulus(1'b1, k, -1);
            tick();
        end
        check_output("basic_no_early_valid", 64'(out_valid), 64'd0);
        apply_stimulus(1'b1, 4, -1);
        check_output("basic_last_ready", 64'(in_ready), 64'd1);
        tick();
        apply_stimulus(1'b0, 0, 0);
        check_output("basic_valid", 64'(out_valid), 64'd1);
        check_output("basic_sum",   out_data,       pack_sum(10, -4));
        check_output("basic_sat",   64'(out_sat),   64'd0);
        tick();
        check_output("basic_drain", 64'(out_valid), 64'd0);

        // cfg_len = 0 behaves as single-beat groups
        cfg_len = 8'd0;
        apply_stimulus(1'b1, 7, 0);
        tick();
        check_output("len0_first_valid", 64'(out_valid), 64'd1);
        check_output("len0_first_sum",   out_data,       pack_sum(7, 0));
        apply_stimulus(1'b1, 8, 0);
        tick();
        check_output("len0_second_valid", 64'(out_valid), 64'd1);
        check_output("len0_second_sum",   out_data,       pack_sum(8, 0));
        apply_stimulus(1'b0, 0, 0);
        tick();
        check_output("len0_drain", 64'(out_valid), 64'd0);

        // Backpressure on the last beat
        cfg_len = 8'd2;
        out_ready = 1'b0;
        apply_stimulus(1'b1, 10, 1);
        tick();
        apply_stimulus(1'b1, 20, 1);
        check_output("bp_g1_last_ready", 64'(in_ready), 64'd1);
        tick();
        check_output("bp_g1_valid", 64'(out_valid), 64'd1);
        check_output("bp_g1_sum",   out_data,       pack_sum(30, 2));
        apply_stimulus(1'b1, 100, -5);
        check_output("bp_nonlast_ready", 64'(in_ready), 64'd1);
        tick();
        apply_stimulus(1'b1, 200, -6);
        check_output("bp_last_stall", 64'(in_ready), 64'd0);
        tick();
        check_output("bp_still_stalled", 64'(in_ready), 64'd0);
        check_output("bp_hold_data",     out_data,       pack_sum(30, 2));
        out_ready = 1'b1;
        #1;
        check_output("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        apply_stimulus(1'b0, 0, 0);
        check_output("bp_no_bubble", 64'(out_valid), 64'd1);
        check_output("bp_g2_sum",    out_data,       pack_sum(300, -11));
        tick();
        check_output("bp_drain", 64'(out_valid), 64'd0);

        // clr aborts the group and blocks the simultaneous beat
        cfg_len = 8'd3;
        apply_stimulus(1'b1, 5, 2);
        tick();
        apply_stimulus(1'b1, 5, 2);
        tick();
        clr = 1'b1;
        apply_stimulus(1'b1, 5, 2);
        check_output("clr_blocks_beat", 64'(in_ready), 64'd0);
        tick();
        clr = 1'b0;
        check_output("clr_no_result", 64'(out_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1, 1);
            tick();
        end
        apply_stimulus(1'b0, 0, 0);
        check_output("clr_valid", 64'(out_valid), 64'd1);
        check_output("clr_sum",   out_data,       pack_sum(3, 3));
        tick();

        // Asynchronous reset with a held result and a group in progress
        cfg_len = 8'd2;
        out_ready = 1'b0;
        apply_stimulus(1'b1, 1, 0);
        tick();
        apply_stimulus(1'b1, 1, 0);
        tick();
        apply_stimulus(1'b1, 4, 0);
        tick();
        apply_stimulus(1'b0, 0, 0);
        check_output("rst_pre_held", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_output("rst_async_valid", 64'(out_valid), 64'd0);
        check_output("rst_async_data",  out_data,       64'd0);
        check_output("rst_async_ready", 64'(in_ready),  64'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check_output("rst_no_stale", 64'(out_valid), 64'd0);
        apply_stimulus(1'b1, 3, 0);
        tick();
        apply_stimulus(1'b1, 3, 0);
        tick();
        apply_stimulus(1'b0, 0, 0);
        check_output("rst_fresh_valid", 64'(out_valid), 64'd1);
        check_output("rst_fresh_sum",   out_data,       pack_sum(6, 0));
        tick();

        // Overflow on the 17-bit instance: eight beats of 32767
        for (int k = 0; k < 7; k++) begin
            ovf_in_valid = 1'b1;
            ovf_in_data  = pack_beat(32767, 0);
            tick();
        end
        check_output("ovf_no_early_valid", 64'(ovf_out_valid), 64'd0);
        tick();
        ovf_in_valid = 1'b0;
        #1;
        check_output("ovf_valid", 64'(ovf_out_valid), 64'd1);
        check_output("ovf_sum",   64'(ovf_out_data),  64'({17'd0, OVF_SUM}));
        check_output("ovf_sat",   64'(ovf_out_sat),   64'(OVF_SAT));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_accum.md
# psum_accum

Multi-lane partial-sum accumulator that sits directly upstream of `stochastic_round`. It sums a configurable number of signed product beats per lane into ACC_W-bit accumulators. Each finished group is presented as a packed `{lane[LANES-1], ..., lane[0]}` word on a valid/ready output, which feeds `stochastic_round.data_in`. A one-entry output register lets the next group accumulate while the previous result waits.

## Interface
- LANES, 2, number of independent lanes
- IN_W, 16, signed input beat width per lane
- ACC_W, 32, signed accumulator/output width per lane (ACC_W > IN_W)
- LEN_W, 8, width of group-length field
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_len  in  LEN_W  beats per group, sampled on first beat of a group; 0 treated as 1
- clr  in  1  synchronous abort of the group in progress
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  LANES*IN_W  packed signed beats, lane 0 in LSBs
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  LANES*ACC_W  packed signed sums, lane 0 in LSBs
- out_sat  out  LANES  per-lane saturation flag for the presented result

## Operation
- FSM states:
  - IDLE: no beats of the current group accepted.
  - ACC: at least one beat accepted, fewer than len.
- IDLE, beat accepted:
  - Latch len = max(cfg_len, 1).
  - acc[i] = sext(in_data[i]); beat_cnt = 1.
  - If len == 1, the beat is also the last beat.
  - Otherwise go to ACC.
- ACC, beat accepted: acc[i] = acc[i] + sext(in_data[i]); beat_cnt++.
- Last beat (beat_cnt reaches len):
  - Sum is loaded into the output register; out_valid = 1.
  - FSM returns to IDLE; accumulators are free for the next group.
- Output register holds until out_valid && out_ready. Without a new load, out_valid then falls on the next edge.
- in_ready = !clr && !(next beat is last && out_valid && !out_ready).
  - Non-last beats are always accepted.
  - A last beat stalls only while an unconsumed result is held.
  - Combinational path out_ready -> in_ready is intentional.
- Last beat accepted in the same cycle the held result is consumed: the new result loads and out_valid stays 1 with no bubble.
- clr:
  - FSM returns to IDLE; beat_cnt and acc cleared.
  - Output register is not affected.
  - Takes priority over a simultaneous beat, which is not accepted because in_ready = 0.
- Arithmetic:
  - Inputs are sign-extended IN_W -> ACC_W.
  - Overflow behaviour is set by the configuration macro.
- out_sat[i] is sticky over the group and loads together with out_data.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_sat = 0; FSM = IDLE, beat_cnt = 0, acc = 0.
- Latency: last beat accepted at edge t -> out_valid = 1 with the sum after edge t (visible in cycle t+1).
- Throughput: one beat per cycle while out_ready = 1; back-to-back groups of len = 1 give one result per cycle.
- cfg_len changes mid-group are ignored until the next group's first beat.
- Reset mid-group or with a held result: everything is discarded immediately (asynchronous); no result is emitted.
- out_data and out_sat are stable while out_valid && !out_ready.

## Configuration
- PSUM_SAT_EN defined:
  - Each lane addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A clamp sets that lane's sticky flag, reported on out_sat.
- PSUM_SAT_EN undefined:
  - Two's-complement wrap-around addition.
  - out_sat is constant 0; no saturation logic is synthesized.

## Test plan
- Reset: assert rst mid-group with a held result -> out_valid = 0, out_data = 0, in_ready = 1 immediately; no stale result after release.
- Basic sum: cfg_len = 4, lane0 beats 1, 2, 3, 4, lane1 beats -1, -1, -1, -1 -> one result 10 / -4, out_valid one cycle after the 4th beat, out_sat = 0.
- len 0 and 1: cfg_len = 0 with beats 7, 8 and out_ready = 1 -> two results 7, 8 on consecutive cycles.
- Backpressure: cfg_len = 2, out_ready = 0 after the first result.
  - Non-last beat of group 2 is accepted.
  - Last beat stalls (in_ready = 0) until out_ready = 1.
  - Then it is accepted in the same cycle; out_valid stays high and the second sum follows.
- clr: cfg_len = 3, two beats of 5, then clr together with a third beat -> beat rejected; the next three beats of 1 give result 3.
- Overflow: IN_W = 16, ACC_W = 17, cfg_len = 8, beats 32767.
  - PSUM_SAT_EN: result 65535, out_sat = 1.
  - Without it: the wrapped value (262136 mod 2^17 as signed = -8), out_sat = 0.
